eth_pcs_rx_block_sync: RTL and testbench

- 10GBASE-R receive block-lock state machine, per IEEE 802.3 Clause 49.2.13.2.2.
- Sits directly downstream of the RX gearbox. Inspects the 2-bit sync header of each 66-bit block and commands bit slips until block boundaries are found.
- Asserts block lock for the RX descrambler/decoder path and keeps monitoring lock once acquired.

---
 rtl/eth_pcs_rx_block_sync.sv | 153 +++++++++++++++
 tb/tb_eth_pcs_rx_block_sync.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_rx_block_sync.sv
// 10GBASE-R receive block-lock FSM: checks 66-bit block sync headers, asks the
// gearbox to slip until boundaries are found, then keeps monitoring lock.
module eth_pcs_rx_block_sync #(
   parameter int unsigned SH_TH       = 64,
   parameter int unsigned SH_INVAL_TH = 16,
   parameter int unsigned SLIP_WAIT   = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   input  logic [1:0] i_sync,
   output logic       o_slip,
   output logic       o_block_lock,
   output logic       o_lock_lost,
   output logic       o_sh_err
);

   localparam int unsigned SH_W   = $clog2(SH_TH) + 1;
   localparam int unsigned INV_W  = $clog2(SH_INVAL_TH) + 1;
   localparam int unsigned SLIP_W = $clog2(SLIP_WAIT) + 1;

   localparam logic [SH_W-1:0]   SH_TH_C       = SH_W'(SH_TH);
   localparam logic [INV_W-1:0]  SH_INVAL_TH_C = INV_W'(SH_INVAL_TH);
   localparam logic [SLIP_W-1:0] SLIP_WAIT_C   = SLIP_W'(SLIP_WAIT);

   localparam logic [1:0] SYNC_DATA = 2'b10;
   localparam logic [1:0] SYNC_CTRL = 2'b01;

   localparam logic [1:0] ST_UNLOCKED  = 2'd0;
   localparam logic [1:0] ST_LOCKED    = 2'd1;
   localparam logic [1:0] ST_SLIP_WAIT = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
   logic [INV_W-1:0]  inval_cnt_q, inval_cnt_d;
   logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
   logic              slip_q, slip_d;
   logic              block_lock_q, block_lock_d;
   logic              lock_lost_q, lock_lost_d;
   logic              sh_err_q, sh_err_d;

   logic              hdr_ok;
   logic [SH_W-1:0]   sh_cnt_inc;
   logic [INV_W-1:0]  inval_cnt_inc;
   logic [SLIP_W-1:0] slip_cnt_inc;

   assign hdr_ok        = (i_sync == SYNC_DATA) || (i_sync == SYNC_CTRL);
   assign sh_cnt_inc    = sh_cnt_q + SH_W'(1);
   assign inval_cnt_inc = inval_cnt_q + INV_W'(1);
   assign slip_cnt_inc  = slip_cnt_q + SLIP_W'(1);

   always_comb begin
      state_d      = state_q;
      sh_cnt_d     = sh_cnt_q;
      inval_cnt_d  = inval_cnt_q;
      slip_cnt_d   = slip_cnt_q;
      block_lock_d = block_lock_q;
      slip_d       = 1'b0;
      lock_lost_d  = 1'b0;
      sh_err_d     = 1'b0;

      if (i_valid) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (hdr_ok) begin
                  if (sh_cnt_inc == SH_TH_C) begin
                     state_d      = ST_LOCKED;
                     block_lock_d = 1'b1;
                     sh_cnt_d     = '0;
                     inval_cnt_d  = '0;
                  end else begin
                     sh_cnt_d = sh_cnt_inc;
                  end
               end else begin
                  state_d    = ST_SLIP_WAIT;
                  slip_d     = 1'b1;
                  sh_cnt_d   = '0;
                  slip_cnt_d = '0;
               end
            end

            ST_LOCKED: begin
               sh_err_d = !hdr_ok;
               // Lock loss is tested first so it wins over a window rollover on the same header.
               if (!hdr_ok && (inval_cnt_inc == SH_INVAL_TH_C)) begin
                  state_d      = ST_SLIP_WAIT;
                  block_lock_d = 1'b0;
                  lock_lost_d  = 1'b1;
                  slip_d       = 1'b1;
                  sh_cnt_d     = '0;
                  inval_cnt_d  = '0;
                  slip_cnt_d   = '0;
               end else if (sh_cnt_inc == SH_TH_C) begin
                  sh_cnt_d    = '0;
                  inval_cnt_d = '0;
               end else begin
                  sh_cnt_d = sh_cnt_inc;
                  if (!hdr_ok) begin
                     inval_cnt_d = inval_cnt_inc;
                  end
               end
            end

            ST_SLIP_WAIT: begin
               if (slip_cnt_inc == SLIP_WAIT_C) begin
                  state_d     = ST_UNLOCKED;
                  slip_cnt_d  = '0;
                  sh_cnt_d    = '0;
                  inval_cnt_d = '0;
               end else begin
                  slip_cnt_d = slip_cnt_inc;
               end
            end

            default: begin
               state_d      = ST_UNLOCKED;
               sh_cnt_d     = '0;
               inval_cnt_d  = '0;
               slip_cnt_d   = '0;
               block_lock_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_UNLOCKED;
         sh_cnt_q     <= '0;
         inval_cnt_q  <= '0;
         slip_cnt_q   <= '0;
         slip_q       <= 1'b0;
         block_lock_q <= 1'b0;
         lock_lost_q  <= 1'b0;
         sh_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_cnt_q     <= sh_cnt_d;
         inval_cnt_q  <= inval_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         slip_q       <= slip_d;
         block_lock_q <= block_lock_d;
         lock_lost_q  <= lock_lost_d;
         sh_err_q     <= sh_err_d;
      end
   end

   assign o_slip       = slip_q;
   assign o_block_lock = block_lock_q;
   assign o_lock_lost  = lock_lost_q;
   assign o_sh_err     = sh_err_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Directed bench for eth_pcs_rx_block_sync: acquisition, slip handling,
// windowed error monitoring, lock loss, sparse input and mid-lock reset.
module tb_eth_pcs_rx_block_sync;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_valid;
   logic [1:0] i_sync;
   logic       o_slip;
   logic       o_block_lock;
   logic       o_lock_lost;
   logic       o_sh_err;

   int n_run  = 0;
   int n_fail = 0;
   int slip_seen, err_seen, lost_seen;

   eth_pcs_rx_block_sync #(
      .SH_TH       (64),
      .SH_INVAL_TH (16),
      .SLIP_WAIT   (2)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_sync       (i_sync),
      .o_slip       (o_slip),
      .o_block_lock (o_block_lock),
      .o_lock_lost  (o_lock_lost),
      .o_sh_err     (o_sh_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle; outputs are sampled 1 ns after the edge that consumed it.
   task automatic beat(input logic v, input logic [1:0] s);
      i_valid = v;
      i_sync  = s;
      @(posedge i_clk);
      #1;
      slip_seen += int'(o_slip);
      err_seen  += int'(o_sh_err);
      lost_seen += int'(o_lock_lost);
   endtask

   task automatic clear_seen();
      slip_seen = 0;
      err_seen  = 0;
      lost_seen = 0;
   endtask

   function automatic logic [1:0] good_hdr(input int i);
      return (i % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_sync  = 2'b00;
      clear_seen();

      // Reset with invalid traffic present
      beat(1'b1, 2'b11);
      beat(1'b1, 2'b11);
      check("rst_slip", o_slip, 0);
      check("rst_lock", o_block_lock, 0);
      check("rst_lost", o_lock_lost, 0);
      check("rst_sh_err", o_sh_err, 0);
      i_rst = 1'b0;

      // Acquisition with 64 back-to-back valid headers
      clear_seen();
      for (int i = 0; i < 63; i++) beat(1'b1, good_hdr(i));
      check("acq_lock_at_63", o_block_lock, 0);
      beat(1'b1, good_hdr(63));
      check("acq_lock_at_64", o_block_lock, 1);
      check("acq_no_slip", slip_seen, 0);

      // Unlocked slip on header 30, two ignored beats, then relock
      i_rst = 1'b1;
      beat(1'b0, 2'b00);
      i_rst = 1'b0;
      check("rst2_lock", o_block_lock, 0);
      clear_seen();
      for (int i = 0; i < 29; i++) beat(1'b1, good_hdr(i));
      check("pre_slip_none", slip_seen, 0);
      beat(1'b1, 2'b11);
      check("slip_pulse", o_slip, 1);
      check("slip_lock_low", o_block_lock, 0);
      beat(1'b1, 2'b00);
      check("slip_one_cycle", o_slip, 0);
      check("slipwait_no_sh_err", o_sh_err, 0);
      beat(1'b1, 2'b00);
      check("slipwait_ignored", slip_seen, 1);
      clear_seen();
      for (int i = 0; i < 63; i++) beat(1'b1, good_hdr(i));
      check("relock_at_63", o_block_lock, 0);
      beat(1'b1, good_hdr(63));
      check("relock_at_64", o_block_lock, 1);
      check("relock_no_slip", slip_seen, 0);

      // Two windows with 15 invalid headers each: lock must hold
      clear_seen();
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 64; i++) begin
            if ((i % 4 == 0) && (i < 60)) beat(1'b1, (i % 8 == 0) ? 2'b00 : 2'b11);
            else                          beat(1'b1, good_hdr(i));
         end
      end
      check("win_lock_held", o_block_lock, 1);
      check("win_sh_err_count", err_seen, 30);
      check("win_no_slip", slip_seen, 0);
      check("win_no_lost", lost_seen, 0);

      // 16th invalid on header 40 of a window
      clear_seen();
      for (int i = 1; i < 40; i++) begin
         if ((i % 2 == 1) && (i < 30)) beat(1'b1, 2'b11);
         else                          beat(1'b1, good_hdr(i));
      end
      check("h40_pre_lock", o_block_lock, 1);
      check("h40_pre_errs", err_seen, 15);
      beat(1'b1, 2'b00);
      check("h40_lock_low", o_block_lock, 0);
      check("h40_lost", o_lock_lost, 1);
      check("h40_slip", o_slip, 1);
      check("h40_sh_err", o_sh_err, 1);
      beat(1'b1, 2'b11);
      check("h40_lost_pulse", o_lock_lost, 0);
      check("h40_slip_pulse", o_slip, 0);
      beat(1'b1, 2'b11);
      check("h40_wait_slips", slip_seen, 1);

      // Relock, then the 16th invalid header is exactly header 64
      clear_seen();
      for (int i = 0; i < 64; i++) beat(1'b1, good_hdr(i));
      check("edge_relock", o_block_lock, 1);
      for (int i = 1; i < 64; i++) beat(1'b1, (i <= 15) ? 2'b11 : good_hdr(i));
      check("edge_pre_lock", o_block_lock, 1);
      beat(1'b1, 2'b11);
      check("edge_lock_low", o_block_lock, 0);
      check("edge_lost", o_lock_lost, 1);
      check("edge_slip", o_slip, 1);
      beat(1'b0, 2'b00);
      beat(1'b1, good_hdr(0));
      beat(1'b1, good_hdr(1));
      check("edge_wait_slips", slip_seen, 1);

      // Sparse input: i_valid every third cycle, 2'b00 on idle cycles
      clear_seen();
      for (int i = 0; i < 64; i++) begin
         beat(1'b0, 2'b00);
         beat(1'b0, 2'b00);
         beat(1'b1, good_hdr(i));
         if (i == 62) check("sparse_lock_at_63", o_block_lock, 0);
      end
      check("sparse_lock_at_64", o_block_lock, 1);
      check("sparse_no_slip", slip_seen, 0);

      // Mid-lock reset, then a full 64 headers to relock
      beat(1'b1, 2'b11);
      check("midlock_sh_err", o_sh_err, 1);
      i_rst = 1'b1;
      beat(1'b1, 2'b11);
      i_rst = 1'b0;
      check("midrst_lock", o_block_lock, 0);
      check("midrst_sh_err", o_sh_err, 0);
      check("midrst_slip", o_slip, 0);
      check("midrst_lost", o_lock_lost, 0);
      clear_seen();
      for (int i = 0; i < 63; i++) beat(1'b1, good_hdr(i));
      check("postrst_lock_at_63", o_block_lock, 0);
      beat(1'b1, good_hdr(63));
      check("postrst_lock_at_64", o_block_lock, 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
